gpio_in_capture: RTL

GPIO_IN_CAPTURE -- requirements
Module: gpio_in_capture

---
 rtl/gpio_agent_pkg.sv | 21 ++
 rtl/gpio_sync.sv | 31 +++
 rtl/gpio_in_capture.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/gpio_agent_pkg.sv
// Shared constants and types for the GPIO input capture block.
package gpio_agent_pkg;

    localparam int GPIO_WIDTH = 8;

    typedef enum logic {
        EDGE_FALL = 1'b0,
        EDGE_RISE = 1'b1
    } edge_t;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } rd_state_t;

    // Pick the strobe event a bit is sensitive to.
    function automatic logic edge_hit(edge_t sel, logic rise, logic fall);
        return (sel == EDGE_RISE) ? rise : fall;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage flop synchronizer. The input lands directly on the first
// flop with no logic in front of it. STAGES must be 2 or more.
module gpio_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/gpio_in_capture.sv
// GPIO input capture: synchronizes the pins and an external strobe,
// captures each bit either every cycle or on a selected strobe edge,
// flags changes as pending interrupts and serves one-cycle reads.
//
// Read FSM
//   state | meaning
//   IDLE  | waiting for rd_req; on a request latch capture into rd_data
//   ACK   | rd_ack high for this one cycle, then back to IDLE
module gpio_in_capture
    import gpio_agent_pkg::*;
#(
    parameter int WIDTH       = GPIO_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gpio,
    input  logic             ext_clk,
    input  logic [WIDTH-1:0] use_ext_clk,
    input  logic [WIDTH-1:0] ext_clk_edge,
    input  logic [WIDTH-1:0] irq_mask,
    input  logic [WIDTH-1:0] irq_clr,
    input  logic             rd_req,
    output logic             rd_ack,
    output logic [WIDTH-1:0] rd_data,
    output logic             irq,
    output logic [WIDTH-1:0] pending
);

    logic [WIDTH-1:0] gpio_s;
    logic             ext_s;
    logic             ext_prev;
    logic             ext_rise;
    logic             ext_fall;
    logic [WIDTH-1:0] load_en;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] capture_next;
    logic [WIDTH-1:0] capture_d;
    logic [WIDTH-1:0] cap_changed;
    rd_state_t        state;
    rd_state_t        state_next;
    logic             rd_ack_c;
    logic             latch_rd;

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync_gpio (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (gpio),
        .q     (gpio_s)
    );

    gpio_sync #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_sync_ext (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ext_clk),
        .q     (ext_s)
    );

    // ext_prev resets to 0, so a strobe already high at reset release
    // is seen as one rising edge once it clears the synchronizer.
    assign ext_rise = ext_s & ~ext_prev;
    assign ext_fall = ~ext_s & ext_prev;

    // Per-bit load enable: free-running bits load every cycle, strobed
    // bits only on their selected edge. Config is used as presented.
    always_comb begin
        load_en = '0;
        for (int i = 0; i < WIDTH; i++) begin
            load_en[i] = ~use_ext_clk[i]
                       | edge_hit(edge_t'(ext_clk_edge[i]), ext_rise, ext_fall);
        end
    end

    // Next capture value: synchronized pin where enabled, hold elsewhere.
    always_comb begin
        capture_next = (gpio_s & load_en) | (capture & ~load_en);
    end

    // Strobe history, capture register and its one-cycle-old copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_prev  <= 1'b0;
            capture   <= '0;
            capture_d <= '0;
        end else begin
            ext_prev  <= ext_s;
            capture   <= capture_next;
            capture_d <= capture;
        end
    end

    assign cap_changed = capture ^ capture_d;

    // Pending flags: a masked change sets, irq_clr clears, set wins.
    // Dropping the mask leaves an already pending flag in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            irq     <= 1'b0;
        end else begin
            pending <= (pending & ~irq_clr) | (cap_changed & irq_mask);
            irq     <= |pending;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Read FSM next state and outputs; requests during ACK are dropped.
    always_comb begin
        state_next = state;
        rd_ack_c   = 1'b0;
        latch_rd   = 1'b0;
        case (state)
            IDLE: begin
                if (rd_req) begin
                    state_next = ACK;
                    latch_rd   = 1'b1;
                end
            end
            ACK: begin
                rd_ack_c   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rd_ack = rd_ack_c;

    // Read data holds the sampled capture only during the ACK cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= latch_rd ? capture : '0;
        end
    end

endmodule
